rs_pool: RTL and testbench

Parametrised reservation station, the successor to the single-issue RS. It holds `ENTRIES` dispatched instructions and snoops `NUM_CDB` common-data-bus channels to wake up pending operands. Each cycle it selects the oldest fully-ready entry and issues it to one execution port through a valid/ready output register. It sits between the dispatcher and an ALU-class functional unit; the ROB drives its flush.

---
 rtl/rs_pool.sv | 190 +++++++++++++++++++
 tb/tb_rs_pool.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rs_pool.sv
// rs_pool: multi-entry reservation station with CDB wakeup,
// oldest-ready select and a valid/ready issue register.
module rs_pool #(
    parameter int ENTRIES = 8,
    parameter int ROB_W = 4,
    parameter int DATA_W = 32,
    parameter int PC_W = 32,
    parameter int OP_W = 6,
    parameter int NUM_CDB = 2,
    localparam int IDX_W = $clog2(ENTRIES)
) (
    input  logic                      clk_in,
    input  logic                      rst_n_in,
    input  logic                      rdy_in,
    input  logic                      flush_in,
    input  logic                      disp_valid_in,
    output logic                      disp_ready_out,
    input  logic [DATA_W-1:0]         disp_a_in,
    input  logic [ROB_W-1:0]          disp_qj_in,
    input  logic [DATA_W-1:0]         disp_vj_in,
    input  logic [ROB_W-1:0]          disp_qk_in,
    input  logic [DATA_W-1:0]         disp_vk_in,
    input  logic [ROB_W-1:0]          disp_dest_in,
    input  logic [PC_W-1:0]           disp_pc_in,
    input  logic [OP_W-1:0]           disp_opcode_in,
    input  logic [NUM_CDB-1:0]        cdb_en_in,
    input  logic [NUM_CDB*ROB_W-1:0]  cdb_tag_in,
    input  logic [NUM_CDB*DATA_W-1:0] cdb_value_in,
    output logic                      iss_valid_out,
    input  logic                      iss_ready_in,
    output logic [DATA_W-1:0]         iss_a_out,
    output logic [DATA_W-1:0]         iss_vj_out,
    output logic [DATA_W-1:0]         iss_vk_out,
    output logic [ROB_W-1:0]          iss_dest_out,
    output logic [PC_W-1:0]           iss_pc_out,
    output logic [OP_W-1:0]           iss_opcode_out,
    output logic [IDX_W:0]            count_out
);

    localparam logic [IDX_W-1:0] AGE_MAX = IDX_W'(ENTRIES - 1);

    logic [ENTRIES-1:0] valid_q;
    logic [DATA_W-1:0]  a_q      [ENTRIES];
    logic [ROB_W-1:0]   qj_q     [ENTRIES];
    logic [DATA_W-1:0]  vj_q     [ENTRIES];
    logic [ROB_W-1:0]   qk_q     [ENTRIES];
    logic [DATA_W-1:0]  vk_q     [ENTRIES];
    logic [ROB_W-1:0]   dest_q   [ENTRIES];
    logic [PC_W-1:0]    pc_q     [ENTRIES];
    logic [OP_W-1:0]    opcode_q [ENTRIES];
    logic [IDX_W-1:0]   age_q    [ENTRIES];

    logic [ROB_W-1:0]   qj_nx [ENTRIES];
    logic [DATA_W-1:0]  vj_nx [ENTRIES];
    logic [ROB_W-1:0]   qk_nx [ENTRIES];
    logic [DATA_W-1:0]  vk_nx [ENTRIES];
    logic [ROB_W-1:0]   dqj, dqk;
    logic [DATA_W-1:0]  dvj, dvk;

    logic [ENTRIES-1:0] ready;
    logic [IDX_W-1:0]   free_idx, sel_idx, sel_age;
    logic               sel_any, disp_fire, iss_load;

    // Lowest enabled channel with a matching nonzero tag supplies the value.
    function automatic logic [ROB_W+DATA_W-1:0] snoop(
        input logic [ROB_W-1:0]          q,
        input logic [DATA_W-1:0]         v,
        input logic [NUM_CDB-1:0]        en,
        input logic [NUM_CDB*ROB_W-1:0]  tags,
        input logic [NUM_CDB*DATA_W-1:0] vals
    );
        logic [ROB_W+DATA_W-1:0] r;
        r = {q, v};
        for (int c = NUM_CDB - 1; c >= 0; c--) begin
            if (en[c] && tags[c*ROB_W +: ROB_W] != '0 &&
                tags[c*ROB_W +: ROB_W] == q) begin
                r = {{ROB_W{1'b0}}, vals[c*DATA_W +: DATA_W]};
            end
        end
        return r;
    endfunction

    always_comb begin
        for (int i = 0; i < ENTRIES; i++) begin
            {qj_nx[i], vj_nx[i]} = snoop(qj_q[i], vj_q[i],
                cdb_en_in, cdb_tag_in, cdb_value_in);
            {qk_nx[i], vk_nx[i]} = snoop(qk_q[i], vk_q[i],
                cdb_en_in, cdb_tag_in, cdb_value_in);
            ready[i] = valid_q[i] && qj_q[i] == '0 && qk_q[i] == '0;
        end
        {dqj, dvj} = snoop(disp_qj_in, disp_vj_in,
            cdb_en_in, cdb_tag_in, cdb_value_in);
        {dqk, dvk} = snoop(disp_qk_in, disp_vk_in,
            cdb_en_in, cdb_tag_in, cdb_value_in);
    end

    always_comb begin
        free_idx = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (!valid_q[i]) free_idx = IDX_W'(i);
        end
    end

    // Strict '>' keeps the lowest index on equal ages.
    always_comb begin
        sel_any = 1'b0;
        sel_idx = '0;
        sel_age = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (ready[i] && (!sel_any || age_q[i] > sel_age)) begin
                sel_any = 1'b1;
                sel_idx = IDX_W'(i);
                sel_age = age_q[i];
            end
        end
    end

    assign disp_ready_out = (count_out != (IDX_W+1)'(ENTRIES));
    assign disp_fire = disp_valid_in && disp_ready_out && !flush_in;
    assign iss_load = sel_any && (!iss_valid_out || iss_ready_in);

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            valid_q <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                a_q[i]      <= '0;
                qj_q[i]     <= '0;
                vj_q[i]     <= '0;
                qk_q[i]     <= '0;
                vk_q[i]     <= '0;
                dest_q[i]   <= '0;
                pc_q[i]     <= '0;
                opcode_q[i] <= '0;
                age_q[i]    <= '0;
            end
            iss_valid_out  <= 1'b0;
            iss_a_out      <= '0;
            iss_vj_out     <= '0;
            iss_vk_out     <= '0;
            iss_dest_out   <= '0;
            iss_pc_out     <= '0;
            iss_opcode_out <= '0;
            count_out      <= '0;
        end else if (rdy_in) begin
            if (flush_in) begin
                valid_q       <= '0;
                iss_valid_out <= 1'b0;
                count_out     <= '0;
            end else begin
                for (int i = 0; i < ENTRIES; i++) begin
                    if (valid_q[i]) begin
                        qj_q[i] <= qj_nx[i];
                        vj_q[i] <= vj_nx[i];
                        qk_q[i] <= qk_nx[i];
                        vk_q[i] <= vk_nx[i];
                        if (disp_fire && age_q[i] != AGE_MAX)
                            age_q[i] <= age_q[i] + IDX_W'(1);
                    end
                end
                if (iss_load) valid_q[sel_idx] <= 1'b0;
                if (disp_fire) begin
                    valid_q[free_idx]  <= 1'b1;
                    a_q[free_idx]      <= disp_a_in;
                    qj_q[free_idx]     <= dqj;
                    vj_q[free_idx]     <= dvj;
                    qk_q[free_idx]     <= dqk;
                    vk_q[free_idx]     <= dvk;
                    dest_q[free_idx]   <= disp_dest_in;
                    pc_q[free_idx]     <= disp_pc_in;
                    opcode_q[free_idx] <= disp_opcode_in;
                    age_q[free_idx]    <= '0;
                end
                if (iss_load) begin
                    iss_valid_out  <= 1'b1;
                    iss_a_out      <= a_q[sel_idx];
                    iss_vj_out     <= vj_q[sel_idx];
                    iss_vk_out     <= vk_q[sel_idx];
                    iss_dest_out   <= dest_q[sel_idx];
                    iss_pc_out     <= pc_q[sel_idx];
                    iss_opcode_out <= opcode_q[sel_idx];
                end else if (iss_ready_in) begin
                    iss_valid_out <= 1'b0;
                end
                count_out <= count_out + (IDX_W+1)'(disp_fire)
                                       - (IDX_W+1)'(iss_load);
            end
        end
    end

endmodule

// File: tb/tb_rs_pool.sv
// tb_rs_pool: vector table plus hand sequences for rs_pool,
// with an in-order scoreboard of expected issues.
module tb_rs_pool;

    logic        clk_in = 1'b0;
    logic        rst_n_in;
    logic        rdy_in;
    logic        flush_in;
    logic        disp_valid_in;
    logic        disp_ready_out;
    logic [31:0] disp_a_in;
    logic [3:0]  disp_qj_in;
    logic [31:0] disp_vj_in;
    logic [3:0]  disp_qk_in;
    logic [31:0] disp_vk_in;
    logic [3:0]  disp_dest_in;
    logic [31:0] disp_pc_in;
    logic [5:0]  disp_opcode_in;
    logic [1:0]  cdb_en_in;
    logic [7:0]  cdb_tag_in;
    logic [63:0] cdb_value_in;
    logic        iss_valid_out;
    logic        iss_ready_in;
    logic [31:0] iss_a_out;
    logic [31:0] iss_vj_out;
    logic [31:0] iss_vk_out;
    logic [3:0]  iss_dest_out;
    logic [31:0] iss_pc_out;
    logic [5:0]  iss_opcode_out;
    logic [3:0]  count_out;

    rs_pool dut (
        .clk_in(clk_in),
        .rst_n_in(rst_n_in),
        .rdy_in(rdy_in),
        .flush_in(flush_in),
        .disp_valid_in(disp_valid_in),
        .disp_ready_out(disp_ready_out),
        .disp_a_in(disp_a_in),
        .disp_qj_in(disp_qj_in),
        .disp_vj_in(disp_vj_in),
        .disp_qk_in(disp_qk_in),
        .disp_vk_in(disp_vk_in),
        .disp_dest_in(disp_dest_in),
        .disp_pc_in(disp_pc_in),
        .disp_opcode_in(disp_opcode_in),
        .cdb_en_in(cdb_en_in),
        .cdb_tag_in(cdb_tag_in),
        .cdb_value_in(cdb_value_in),
        .iss_valid_out(iss_valid_out),
        .iss_ready_in(iss_ready_in),
        .iss_a_out(iss_a_out),
        .iss_vj_out(iss_vj_out),
        .iss_vk_out(iss_vk_out),
        .iss_dest_out(iss_dest_out),
        .iss_pc_out(iss_pc_out),
        .iss_opcode_out(iss_opcode_out),
        .count_out(count_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic [5:0]  op;
        logic [31:0] a;
        logic [3:0]  qj;
        logic [31:0] vj;
        logic [3:0]  qk;
        logic [31:0] vk;
        logic [3:0]  dest;
        logic [31:0] pc;
        logic [1:0]  cen;
        logic [3:0]  t0;
        logic [31:0] v0;
        logic [3:0]  t1;
        logic [31:0] v1;
        logic [31:0] evj;
        logic [31:0] evk;
    } vec_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] vj;
        logic [31:0] vk;
        logic [31:0] pc;
        logic [3:0]  dest;
        logic [5:0]  op;
    } iss_t;

    localparam int NV = 6;
    vec_t vecs [NV];
    iss_t exp_q [$];
    iss_t hx, hy;
    int checks = 0;
    int errors = 0;

    function automatic iss_t mk(input logic [5:0] op,
                                input logic [31:0] a, vj, vk,
                                input logic [3:0] dest,
                                input logic [31:0] pc);
        iss_t e;
        e.op = op; e.a = a; e.vj = vj; e.vk = vk;
        e.dest = dest; e.pc = pc;
        return e;
    endfunction

    function automatic logic [159:0] pk(input iss_t e);
        return 160'({e.a, e.vj, e.vk, e.pc, e.dest, e.op});
    endfunction

    function automatic logic [159:0] iss_now();
        return 160'({iss_a_out, iss_vj_out, iss_vk_out,
                     iss_pc_out, iss_dest_out, iss_opcode_out});
    endfunction

    task automatic chk(input string name,
                       input logic [159:0] act,
                       input logic [159:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    // Handshakes are sampled on the falling edge ahead of each rising edge.
    task automatic tick();
        iss_t e;
        @(negedge clk_in);
        if (rst_n_in && rdy_in && iss_valid_out && iss_ready_in) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL issue_unexpected: got %0h want none",
                         iss_now());
            end else begin
                e = exp_q.pop_front();
                chk("issue", iss_now(), pk(e));
            end
        end
        @(posedge clk_in);
        #1;
    endtask

    task automatic disp(input logic [5:0] op, input logic [31:0] a,
                        input logic [3:0] qj, input logic [31:0] vj,
                        input logic [3:0] qk, input logic [31:0] vk,
                        input logic [3:0] dest, input logic [31:0] pc);
        disp_opcode_in = op;
        disp_a_in      = a;
        disp_qj_in     = qj;
        disp_vj_in     = vj;
        disp_qk_in     = qk;
        disp_vk_in     = vk;
        disp_dest_in   = dest;
        disp_pc_in     = pc;
        disp_valid_in  = 1'b1;
        tick();
        disp_valid_in  = 1'b0;
    endtask

    initial begin
        vecs[0] = '{6'h10, 32'h0, 4'h0, 32'h5, 4'h0, 32'h7, 4'h3,
                    32'h100, 2'b00, 4'h0, 32'h0, 4'h0, 32'h0,
                    32'h5, 32'h7};
        vecs[1] = '{6'h11, 32'h1234, 4'h0, 32'hA, 4'h4, 32'h0, 4'h5,
                    32'h104, 2'b01, 4'h4, 32'h9, 4'h0, 32'h0,
                    32'hA, 32'h9};
        vecs[2] = '{6'h12, 32'h0, 4'h6, 32'h0, 4'h0, 32'h3, 4'h6,
                    32'h108, 2'b10, 4'h0, 32'h0, 4'h6, 32'h66,
                    32'h66, 32'h3};
        vecs[3] = '{6'h13, 32'hFFFF_FFFF, 4'h7, 32'h0, 4'h7, 32'h0,
                    4'h7, 32'h10C, 2'b11, 4'h7, 32'h70, 4'h7, 32'h71,
                    32'h70, 32'h70};
        vecs[4] = '{6'h14, 32'h0, 4'h0, 32'h11, 4'h2, 32'h0, 4'h8,
                    32'h110, 2'b11, 4'h0, 32'hDEAD, 4'h2, 32'h22,
                    32'h11, 32'h22};
        vecs[5] = '{6'h3F, 32'h5A5A, 4'hF, 32'h0, 4'h0, 32'h44, 4'hF,
                    32'hFFFF_FFFC, 2'b01, 4'hF, 32'h33, 4'hF, 32'h34,
                    32'h33, 32'h44};

        rst_n_in = 1'b0;
        rdy_in = 1'b1;
        flush_in = 1'b0;
        disp_valid_in = 1'b0;
        disp_a_in = '0;
        disp_qj_in = '0;
        disp_vj_in = '0;
        disp_qk_in = '0;
        disp_vk_in = '0;
        disp_dest_in = '0;
        disp_pc_in = '0;
        disp_opcode_in = '0;
        cdb_en_in = '0;
        cdb_tag_in = '0;
        cdb_value_in = '0;
        iss_ready_in = 1'b0;

        #12;
        chk("rst_iss_valid", iss_valid_out, 0);
        chk("rst_count", count_out, 0);
        chk("rst_disp_ready", disp_ready_out, 1);
        chk("rst_iss_data", iss_now(), 0);
        rst_n_in = 1'b1;
        @(posedge clk_in);
        #1;

        // Vector table: one-cycle latency, wakeup bypass, channel priority.
        iss_ready_in = 1'b1;
        for (int k = 0; k < NV; k++) begin
            cdb_en_in = vecs[k].cen;
            cdb_tag_in = {vecs[k].t1, vecs[k].t0};
            cdb_value_in = {vecs[k].v1, vecs[k].v0};
            exp_q.push_back(mk(vecs[k].op, vecs[k].a, vecs[k].evj,
                               vecs[k].evk, vecs[k].dest, vecs[k].pc));
            disp(vecs[k].op, vecs[k].a, vecs[k].qj, vecs[k].vj,
                 vecs[k].qk, vecs[k].vk, vecs[k].dest, vecs[k].pc);
            cdb_en_in = '0;
            tick();
            chk("lat_valid", iss_valid_out, 1);
            chk("lat_count", count_out, 0);
        end
        tick();
        chk("tbl_idle", iss_valid_out, 0);

        // Ready B overtakes older A, which later wakes from channel 1.
        disp(6'h20, 32'h0, 4'h2, 32'h0, 4'h0, 32'h1, 4'h1, 32'h200);
        exp_q.push_back(mk(6'h21, 32'h0, 32'h3, 32'h4, 4'h2, 32'h204));
        disp(6'h21, 32'h0, 4'h0, 32'h3, 4'h0, 32'h4, 4'h2, 32'h204);
        exp_q.push_back(mk(6'h20, 32'h0, 32'h55, 32'h1, 4'h1, 32'h200));
        cdb_en_in = 2'b10;
        cdb_tag_in = {4'h2, 4'h0};
        cdb_value_in = {32'h55, 32'h0};
        tick();
        cdb_en_in = '0;
        tick();
        tick();
        chk("ooo_count", count_out, 0);
        chk("ooo_idle", iss_valid_out, 0);

        // Fill all entries on tag 1, then drain in dispatch order.
        for (int k = 0; k < 8; k++) begin
            exp_q.push_back(mk(6'(6'h30 + k), 32'(k), 32'h77,
                               32'(k + 100), 4'(k + 8), 32'(32'h300 + 4 * k)));
            disp(6'(6'h30 + k), 32'(k), 4'h1, 32'h0, 4'h0,
                 32'(k + 100), 4'(k + 8), 32'(32'h300 + 4 * k));
        end
        chk("full_count", count_out, 8);
        chk("full_ready", disp_ready_out, 0);
        disp(6'h3E, 32'hBAD, 4'h0, 32'h1, 4'h0, 32'h2, 4'h1, 32'h3FC);
        chk("full_drop", count_out, 8);
        cdb_en_in = 2'b01;
        cdb_tag_in = {4'h0, 4'h1};
        cdb_value_in = {32'h0, 32'h77};
        tick();
        cdb_en_in = '0;
        for (int k = 0; k < 8; k++) begin
            tick();
            chk("burst_valid", iss_valid_out, 1);
        end
        tick();
        chk("burst_idle", iss_valid_out, 0);
        chk("burst_count", count_out, 0);

        // Backpressure: the held instruction must not change.
        iss_ready_in = 1'b0;
        hx = mk(6'h01, 32'hAA, 32'h11, 32'h12, 4'h4, 32'h400);
        hy = mk(6'h02, 32'hBB, 32'h21, 32'h22, 4'h5, 32'h404);
        exp_q.push_back(hx);
        exp_q.push_back(hy);
        disp(hx.op, hx.a, 4'h0, hx.vj, 4'h0, hx.vk, hx.dest, hx.pc);
        disp(hy.op, hy.a, 4'h0, hy.vj, 4'h0, hy.vk, hy.dest, hy.pc);
        chk("hold_valid", iss_valid_out, 1);
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("hold_data", iss_now(), pk(hx));
            chk("hold_count", count_out, 1);
        end
        iss_ready_in = 1'b1;
        tick();
        chk("release_next", iss_dest_out, hy.dest);
        tick();
        chk("release_idle", iss_valid_out, 0);

        // Flush with occupied entries, a held issue and a dispatch.
        iss_ready_in = 1'b0;
        for (int k = 0; k < 6; k++) begin
            disp(6'h05, 32'(k), 4'h0, 32'h1, 4'h0, 32'h2,
                 4'(k + 1), 32'(32'h500 + 4 * k));
        end
        chk("pre_flush_count", count_out, 5);
        chk("pre_flush_valid", iss_valid_out, 1);
        flush_in = 1'b1;
        disp(6'h06, 32'h0, 4'h0, 32'h1, 4'h0, 32'h2, 4'h9, 32'h600);
        flush_in = 1'b0;
        chk("flush_count", count_out, 0);
        chk("flush_valid", iss_valid_out, 0);
        chk("flush_ready", disp_ready_out, 1);
        tick();
        tick();
        chk("flush_discard", iss_valid_out, 0);

        // Global stall ignores a dispatch.
        rdy_in = 1'b0;
        disp(6'h07, 32'h0, 4'h0, 32'h1, 4'h0, 32'h2, 4'h3, 32'h700);
        chk("stall_count", count_out, 0);
        rdy_in = 1'b1;
        tick();
        chk("stall_valid", iss_valid_out, 0);

        // Asynchronous reset between clock edges.
        disp(6'h08, 32'h0, 4'h0, 32'h1, 4'h0, 32'h2, 4'h7, 32'h800);
        disp(6'h09, 32'h0, 4'h0, 32'h3, 4'h0, 32'h4, 4'h8, 32'h804);
        chk("pre_rst_valid", iss_valid_out, 1);
        chk("pre_rst_count", count_out, 1);
        #2;
        rst_n_in = 1'b0;
        #1;
        chk("arst_valid", iss_valid_out, 0);
        chk("arst_count", count_out, 0);
        chk("arst_data", iss_now(), 0);
        #1;
        rst_n_in = 1'b1;
        @(posedge clk_in);
        #1;
        tick();
        chk("post_rst_valid", iss_valid_out, 0);
        chk("sb_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
